sync_ram_dp: RTL and testbench
==============================

SYNC_RAM_DP -- requirements
Module: sync_ram_dp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 clr  input  1  single-cycle request to zero the whole array.
REQ-007 we  input  1  write enable.
REQ-008 waddr  input  ADDR_WIDTH  write address.
REQ-009 wdata  input  DATA_WIDTH  write data.
REQ-010 re  input  1  read enable.
REQ-011 raddr  input  ADDR_WIDTH  read address.
REQ-012 rdata  output  DATA_WIDTH  read data; holds last value when no read completes.
REQ-013 rvalid  output  1  one-cycle pulse marking rdata valid.
REQ-014 busy  output  1  high while the clear sequence runs.

Function
REQ-015 SHALL use separate write and read ports; both usable in the same cycle.
REQ-016 Write SHALL commit wdata to mem[waddr] on the rising edge where we=1 and busy=0.
REQ-017 Read SHALL present mem[raddr] on rdata with rvalid=1 one cycle after the edge sampling re=1, busy=0 (macro off).
REQ-018 Same-cycle we, re, waddr==raddr SHALL return the new wdata (write-first bypass).
REQ-019 Control FSM SHALL have states IDLE and CLEAR, with a clear counter of width ADDR_WIDTH.
REQ-020 IDLE->CLEAR on the first edge after rst_n rises, or on clr=1 while in IDLE.
REQ-021 CLEAR SHALL write zero to address 0..DEPTH-1, one per cycle, counter incrementing from 0.
REQ-022 CLEAR->IDLE on the edge writing DEPTH-1; counter SHALL NOT wrap into a second pass.
REQ-023 busy SHALL be 1 exactly while in CLEAR: DEPTH cycles per clear.
REQ-024 During busy: we and re SHALL be ignored, rvalid=0, clr ignored (no restart).
REQ-025 A read accepted on the edge entering CLEAR SHALL still complete with its pre-clear data.
REQ-026 Memory array SHALL NOT be asynchronously reset; only the clear sequence zeroes it.

Reset
REQ-027 rst_n=0 SHALL force rdata=0, rvalid=0, busy=0, FSM=IDLE, counter=0 immediately.
REQ-028 rst_n asserted mid-clear SHALL abort it; after release a full clear SHALL restart from address 0.

Configuration
REQ-029 Macro SYNC_RAM_OUT_REG_EN defined: extra output register stage; read latency 2 cycles, rvalid delayed identically, reset value 0, in-flight reads still complete during busy.
REQ-030 Macro undefined: read latency 1 cycle as REQ-017; no extra stage.

Structure
REQ-031 Package sync_ram_pkg SHALL hold the FSM state typedef (IDLE, CLEAR) and default DATA_WIDTH/ADDR_WIDTH constants.
REQ-032 Clear FSM and counter SHALL be sub-module sync_ram_clear_ctrl (outputs busy, clear address, clear write strobe); array and read path stay in sync_ram_dp.

Verification
REQ-033 Release rst_n -> busy=1 for exactly 16 cycles; then reads of all 16 addresses return 8'h00.
REQ-034 Write 8'hA5 @3, then re @3 next cycle -> rdata=8'hA5, rvalid=1 after 1 cycle (2 with macro).
REQ-035 Same cycle we=1 waddr=7 wdata=8'h3C, re=1 raddr=7 -> rdata=8'h3C.
REQ-036 Fill all addresses with 8'hFF, pulse clr -> busy 16 cycles, we/re during busy ignored (rvalid=0), then all reads 8'h00.
REQ-037 Assert rst_n=0 at clear count 5 -> outputs 0 immediately; after release busy 16 cycles, addresses 6..15 read 8'h00.
REQ-038 Run REQ-034 with DATA_WIDTH=16, ADDR_WIDTH=6 -> 64-cycle clear, 16-bit data correct.

Source files
------------

// File: rtl/sync_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ram_pkg
//  Description : Shared constants for the sync_ram_dp dual-port RAM slice:
//                default geometry and the clear-controller state encoding.
//  Config      : none (the SYNC_RAM_OUT_REG_EN macro is consumed by sync_ram_dp)
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_ram_pkg;

    // Default geometry: 16 words of 8 bits
    localparam int C_DEF_DATA_WIDTH = 8;
    localparam int C_DEF_ADDR_WIDTH = 4;

    // Clear-controller FSM state type and encodings
    typedef logic [0:0] clr_state_t;
    localparam clr_state_t C_ST_IDLE  = 1'b0;
    localparam clr_state_t C_ST_CLEAR = 1'b1;

endpackage : sync_ram_pkg
`default_nettype wire

// File: rtl/sync_ram_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ram_clear_ctrl
//  Description : Two-state (IDLE/CLEAR) controller that sweeps the RAM array
//                with zeroes, one address per cycle, from 0 to DEPTH-1.
//                A sweep starts on the first edge after reset release and on
//                a clear request seen while idle.
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                i_clr      - clear request (ignored while a sweep runs)
//                o_busy     - high for every cycle spent in CLEAR
//                o_clr_addr - address being zeroed this cycle
//                o_clr_we   - zero-write strobe for o_clr_addr
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ram_clear_ctrl
    import sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = C_DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    output logic                  o_busy,
    output logic [ADDR_WIDTH-1:0] o_clr_addr,
    output logic                  o_clr_we
);

    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = '1;

    clr_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    // Set by reset so that the first edge after release launches a sweep
    logic                  r_init_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= C_ST_IDLE;
            r_cnt       <= '0;
            r_init_pend <= 1'b1;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (r_init_pend || i_clr) begin
                        r_state     <= C_ST_CLEAR;
                        r_cnt       <= '0;
                        r_init_pend <= 1'b0;
                    end
                end
                C_ST_CLEAR: begin
                    // Leave on the edge that zeroes the last word; the
                    // counter is parked at 0 instead of wrapping on.
                    if (r_cnt == C_LAST_ADDR) begin
                        r_state <= C_ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_busy     = (r_state == C_ST_CLEAR);
    assign o_clr_we   = (r_state == C_ST_CLEAR);
    assign o_clr_addr = r_cnt;

endmodule : sync_ram_clear_ctrl
`default_nettype wire

// File: rtl/sync_ram_dp.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ram_dp
//  Description : Simple dual-port synchronous RAM (one write port, one read
//                port, single clock) with write-first bypass and a hardware
//                clear sequence that zeroes the whole array.
//  Config      : SYNC_RAM_OUT_REG_EN - when defined, adds a second output
//                register stage (read latency 2, rvalid delayed to match).
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset (not applied to array)
//                clr    - request to zero the whole array
//                we     - write enable      waddr/wdata - write address/data
//                re     - read enable       raddr       - read address
//                rdata  - read data, holds last value between reads
//                rvalid - one-cycle pulse qualifying rdata
//                busy   - high while the clear sequence runs
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ram_dp
    import sync_ram_pkg::*;
#(
    parameter int DATA_WIDTH = C_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_busy;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_clr_we;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_bypass;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    sync_ram_clear_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (clr),
        .o_busy     (w_busy),
        .o_clr_addr (w_clr_addr),
        .o_clr_we   (w_clr_we)
    );

    // User ports are locked out for the whole clear sweep
    assign w_wr_en  = we && !w_busy;
    assign w_rd_en  = re && !w_busy;
    assign w_bypass = w_wr_en && (waddr == raddr);

    // Array has no reset; only the clear sweep zeroes it
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Write-first: a same-address write in the same cycle wins over the array
    assign w_rd_word = w_bypass ? wdata : r_mem[raddr];

    // First read stage; rdata holds its value when no read is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd_en;
            if (w_rd_en) begin
                r_rdata <= w_rd_word;
            end
        end
    end

`ifdef SYNC_RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] r_rdata_q;
    logic                  r_rvalid_q;

    // Free-running second stage so a read already in flight still
    // completes after busy rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata_q  <= '0;
            r_rvalid_q <= 1'b0;
        end else begin
            r_rdata_q  <= r_rdata;
            r_rvalid_q <= r_rvalid;
        end
    end

    assign rdata  = r_rdata_q;
    assign rvalid = r_rvalid_q;
`else
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
`endif

    assign busy = w_busy;

endmodule : sync_ram_dp
`default_nettype wire

// File: tb/tb_sync_ram_dp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_ram_dp
//  Description : Self-checking bench for sync_ram_dp. Covers the 8x16 default
//                build (directed sequences, a vector table and a random run
//                against a reference model) and a 16x64 instance.
//  Config      : honours SYNC_RAM_OUT_REG_EN (expected read latency 2)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_ram_dp;

`ifdef SYNC_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DW     = 8;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int DW2    = 16;
    localparam int AW2    = 6;
    localparam int DEPTH2 = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-geometry instance
    logic          rst_n, clr, we, re;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata, rdata;
    logic          rvalid, busy;

    // Wide instance
    logic           rst2_n, clr2, we2, re2;
    logic [AW2-1:0] waddr2, raddr2;
    logic [DW2-1:0] wdata2, rdata2;
    logic           rvalid2, busy2;

    int n_checks = 0;
    int n_errors = 0;

    sync_ram_dp u_dut (
        .clk    (clk),    .rst_n  (rst_n),  .clr    (clr),
        .we     (we),     .waddr  (waddr),  .wdata  (wdata),
        .re     (re),     .raddr  (raddr),  .rdata  (rdata),
        .rvalid (rvalid), .busy   (busy)
    );

    sync_ram_dp #(.DATA_WIDTH(DW2), .ADDR_WIDTH(AW2)) u_dut_wide (
        .clk    (clk),     .rst_n  (rst2_n), .clr    (clr2),
        .we     (we2),     .waddr  (waddr2), .wdata  (wdata2),
        .re     (re2),     .raddr  (raddr2), .rdata  (rdata2),
        .rvalid (rvalid2), .busy   (busy2)
    );

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called just after an edge where busy was seen high; returns total busy cycles
    task automatic count_busy(input bit wide, output int n);
        n = 1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if ((wide ? busy2 : busy) !== 1'b1) return;
            n++;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] e);
        re = 1'b1; raddr = a;
        @(posedge clk); #1;
        re = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            chk_bit({nm, "_early"}, rvalid, 1'b0);
            @(posedge clk); #1;
        end
        chk_bit({nm, "_rvalid"}, rvalid, 1'b1);
        chk_data({nm, "_rdata"}, {8'h00, rdata}, {8'h00, e});
    endtask

    task automatic rd_chk2(input string nm, input logic [AW2-1:0] a, input logic [DW2-1:0] e);
        re2 = 1'b1; raddr2 = a;
        @(posedge clk); #1;
        re2 = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            chk_bit({nm, "_early"}, rvalid2, 1'b0);
            @(posedge clk); #1;
        end
        chk_bit({nm, "_rvalid"}, rvalid2, 1'b1);
        chk_data({nm, "_rdata"}, rdata2, e);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          re;
        logic [AW-1:0] raddr;
        logic          exp_rvalid;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    int            m_clear_left;
    bit            m_init;
    logic          m_rvalid, m_v1;
    logic [DW-1:0] m_rdata, m_d1;

    initial begin
        int            n;
        logic          t_we, t_re, t_clr, a_v, bb;
        logic [AW-1:0] t_waddr, t_raddr;
        logic [DW-1:0] t_wdata, a_d;

        // write A5@3 then read it, bypass, hold on re=0, boundary addresses
        vecs[0] = '{1'b1, 4'd3,  8'hA5, 1'b0, 4'd0,  1'b0, 8'h00};
        vecs[1] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  1'b1, 8'hA5};
        vecs[2] = '{1'b1, 4'd7,  8'h3C, 1'b1, 4'd7,  1'b1, 8'h3C};
        vecs[3] = '{1'b1, 4'd5,  8'h11, 1'b1, 4'd3,  1'b1, 8'hA5};
        vecs[4] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd5,  1'b1, 8'h11};
        vecs[5] = '{1'b1, 4'd0,  8'hFF, 1'b1, 4'd15, 1'b1, 8'h00};
        vecs[6] = '{1'b1, 4'd15, 8'h80, 1'b1, 4'd0,  1'b1, 8'hFF};
        vecs[7] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 1'b1, 8'h80};
        vecs[8] = '{1'b1, 4'd15, 8'h42, 1'b0, 4'd0,  1'b0, 8'h80};
        vecs[9] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 1'b1, 8'h42};

        rst_n = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0;
        waddr = '0; raddr = '0; wdata = '0;
        rst2_n = 1'b0; clr2 = 1'b0; we2 = 1'b0; re2 = 1'b0;
        waddr2 = '0; raddr2 = '0; wdata2 = '0;

        // ---- Reset state and power-up clear ----
        #3;
        chk_data("rst_rdata", {8'h00, rdata}, 16'h0000);
        chk_bit("rst_rvalid", rvalid, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        chk_bit("rst_hold_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_bit("init_busy_start", busy, 1'b1);
        count_busy(1'b0, n);
        chk_int("init_busy_cycles", n, DEPTH);
        for (int i = 0; i < DEPTH; i++) rd_chk($sformatf("init_rd%0d", i), AW'(i), 8'h00);

        // ---- Vector table ----
        for (int i = 0; i < 10; i++) begin
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            re = vecs[i].re; raddr = vecs[i].raddr;
            @(posedge clk); #1;
            we = 1'b0; re = 1'b0;
            for (int k = 1; k < LAT; k++) begin
                chk_bit($sformatf("vec%0d_early", i), rvalid, 1'b0);
                @(posedge clk); #1;
            end
            chk_bit($sformatf("vec%0d_rvalid", i), rvalid, vecs[i].exp_rvalid);
            chk_data($sformatf("vec%0d_rdata", i), {8'h00, rdata}, {8'h00, vecs[i].exp_rdata});
        end

        // ---- Fill with FF, clear, accesses during busy ignored ----
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 8'hFF);
        clr = 1'b1;
        @(posedge clk); #1;
        chk_bit("clr_busy_start", busy, 1'b1);
        n = 1;
        for (int k = 0; k < 100 && busy; k++) begin
            clr = 1'b1; we = 1'b1; waddr = AW'($urandom); wdata = 8'h77;
            re = 1'b1; raddr = AW'($urandom);
            @(posedge clk); #1;
            chk_bit("clr_rvalid_low", rvalid, 1'b0);
            if (busy) n++;
        end
        clr = 1'b0; we = 1'b0; re = 1'b0;
        chk_int("clr_busy_cycles", n, DEPTH);
        for (int i = 0; i < DEPTH; i++) rd_chk($sformatf("clr_rd%0d", i), AW'(i), 8'h00);

        // ---- Reset in the middle of a clear ----
        for (int i = 6; i < DEPTH; i++) wr(AW'(i), 8'hFF);
        rd_chk("pre_rst_rd", 4'd9, 8'hFF);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk_bit("midclr_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_data("midrst_rdata", {8'h00, rdata}, 16'h0000);
        chk_bit("midrst_rvalid", rvalid, 1'b0);
        chk_bit("midrst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_bit("rerun_busy_start", busy, 1'b1);
        count_busy(1'b0, n);
        chk_int("rerun_busy_cycles", n, DEPTH);
        for (int i = 6; i < DEPTH; i++) rd_chk($sformatf("rerun_rd%0d", i), AW'(i), 8'h00);

        // ---- Random traffic against the reference model ----
        rst_n = 1'b0;
        m_clear_left = 0; m_init = 1'b1;
        m_rvalid = 1'b0; m_rdata = '0; m_v1 = 1'b0; m_d1 = '0;
        #1;
        chk_data("rnd_rst_rdata", {8'h00, rdata}, {8'h00, m_rdata});
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            t_we    = 1'($urandom);
            t_waddr = AW'($urandom);
            t_wdata = DW'($urandom);
            t_re    = (c == 0) ? 1'b0 : 1'($urandom);
            t_raddr = ($urandom_range(0, 3) == 0) ? t_waddr : AW'($urandom);
            t_clr   = ($urandom_range(0, 49) == 0);
            we = t_we; waddr = t_waddr; wdata = t_wdata;
            re = t_re; raddr = t_raddr; clr = t_clr;
            @(posedge clk); #1;

            bb  = (m_clear_left > 0);
            a_v = t_re && !bb;
            a_d = (t_we && t_waddr == t_raddr) ? t_wdata : m_mem[t_raddr];
            if (!bb && t_we) m_mem[t_waddr] = t_wdata;
            if (bb) begin
                m_clear_left--;
            end else if (m_init || t_clr) begin
                // whole array reads as zero once the sweep is over, and
                // nothing can access it while the sweep runs
                m_clear_left = DEPTH;
                m_init = 1'b0;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end
            if (LAT == 1) begin
                m_rvalid = a_v;
                if (a_v) m_rdata = a_d;
            end else begin
                m_rvalid = m_v1;
                m_rdata  = m_d1;
                m_v1     = a_v;
                if (a_v) m_d1 = a_d;
            end

            chk_bit("rnd_busy", busy, (m_clear_left > 0));
            chk_bit("rnd_rvalid", rvalid, m_rvalid);
            chk_data("rnd_rdata", {8'h00, rdata}, {8'h00, m_rdata});
        end
        we = 1'b0; re = 1'b0; clr = 1'b0;

        // ---- Wide instance: 16-bit data, 64-word clear ----
        chk_bit("w_rst_busy", busy2, 1'b0);
        chk_data("w_rst_rdata", rdata2, 16'h0000);
        rst2_n = 1'b1;
        @(posedge clk); #1;
        chk_bit("w_busy_start", busy2, 1'b1);
        count_busy(1'b1, n);
        chk_int("w_busy_cycles", n, DEPTH2);
        we2 = 1'b1; waddr2 = 6'd3; wdata2 = 16'hA5C3;
        @(posedge clk); #1;
        we2 = 1'b0;
        rd_chk2("w_rd3", 6'd3, 16'hA5C3);
        we2 = 1'b1; waddr2 = 6'd63; wdata2 = 16'h8001;
        @(posedge clk); #1;
        we2 = 1'b0;
        rd_chk2("w_rd63", 6'd63, 16'h8001);
        rd_chk2("w_rd40", 6'd40, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sync_ram_dp
`default_nettype wire
